vram_xfer_seq: RTL and testbench

VRAM_XFER_SEQ -- requirements
Module: vram_xfer_seq

---
 rtl/vram_pkg.sv | 18 +
 rtl/vs_edge_det.sv | 30 +++
 rtl/vram_xfer_seq.sv | 201 ++++++++++++++++++++
 tb/tb_vram_xfer_seq.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM transfer sequencer.
//   VRAM_ADDR_W / VRAM_DATA_W : default address and data widths
//   xfer_state_t              : sequencer state encoding
package vram_pkg;

    localparam int unsigned VRAM_ADDR_W = 16;
    localparam int unsigned VRAM_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        W_FETCH,
        W_REQ,
        W_ACK,
        R_REQ,
        R_WAIT
    } xfer_state_t;

endpackage

// File: rtl/vs_edge_det.sv
// Rising-edge detector for the vertical sync level.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   vs      : vertical sync level
//   vs_rise : combinational pulse in the cycle vs first reads high after being low
module vs_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic vs,
    output logic vs_rise
);

    logic vs_q;
    logic armed_q;

    // armed_q stays low until vs has been seen low once after reset, so a
    // vs that is already high when reset releases does not look like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            vs_q    <= vs;
            armed_q <= armed_q | ~vs;
        end
    end

    assign vs_rise = vs & ~vs_q & armed_q;

endmodule

// File: rtl/vram_xfer_seq.sv
// VRAM transfer sequencer: on each vs rising edge writes WR_WORDS source words
// to VRAM starting at WR_BASE; on each rd_start pulse reads RD_WORDS words from
// RD_BASE and hands them to a sink.
//   clk, reset_n          : clock, asynchronous active-low reset
//   vs, rd_start          : write-burst trigger (level), read-burst request (pulse)
//   wr_full, rd_empty     : VRAM FIFO status
//   readdata              : VRAM read data
//   src_idx / src_data    : source word index out, source word in
//   write/writeaddr/writedata, read/readaddr : VRAM request outputs
//   sink_we/sink_idx/sink_data : captured read words
//   busy, wr_done, rd_done, rd_err : status
module vram_xfer_seq #(
    parameter int unsigned ADDR_W   = vram_pkg::VRAM_ADDR_W,
    parameter int unsigned DATA_W   = vram_pkg::VRAM_DATA_W,
    parameter int unsigned WR_WORDS = 4,
    parameter int unsigned RD_WORDS = 4,
    parameter int unsigned WR_BASE  = 0,
    parameter int unsigned RD_BASE  = 0,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vs,
    input  logic              rd_start,
    input  logic              wr_full,
    input  logic              rd_empty,
    input  logic [DATA_W-1:0] readdata,
    input  logic [DATA_W-1:0] src_data,
    output logic [ADDR_W-1:0] src_idx,
    output logic              write,
    output logic              read,
    output logic [ADDR_W-1:0] writeaddr,
    output logic [ADDR_W-1:0] readaddr,
    output logic [DATA_W-1:0] writedata,
    output logic              sink_we,
    output logic [ADDR_W-1:0] sink_idx,
    output logic [DATA_W-1:0] sink_data,
    output logic              busy,
    output logic              wr_done,
    output logic              rd_done,
    output logic              rd_err
);

    import vram_pkg::*;

    localparam int unsigned TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] WR_LAST  = ADDR_W'(WR_WORDS - 1);
    localparam logic [ADDR_W-1:0] RD_LAST  = ADDR_W'(RD_WORDS - 1);
    localparam logic [ADDR_W-1:0] WR_START = ADDR_W'(WR_BASE);
    localparam logic [ADDR_W-1:0] RD_START = ADDR_W'(RD_BASE);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

    xfer_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic              vs_rise;

    logic [ADDR_W-1:0] src_idx_d, writeaddr_d, readaddr_d, sink_idx_d;
    logic [DATA_W-1:0] writedata_d, sink_data_d;
    logic              write_d, read_d, sink_we_d, wr_done_d, rd_done_d, rd_err_d;

    vs_edge_det u_vs_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .vs      (vs),
        .vs_rise (vs_rise)
    );

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tmr_q     <= '0;
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            src_idx   <= '0;
            write     <= 1'b0;
            writeaddr <= '0;
            writedata <= '0;
            read      <= 1'b0;
            readaddr  <= '0;
            sink_we   <= 1'b0;
            sink_idx  <= '0;
            sink_data <= '0;
            wr_done   <= 1'b0;
            rd_done   <= 1'b0;
            rd_err    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
            src_idx   <= src_idx_d;
            write     <= write_d;
            writeaddr <= writeaddr_d;
            writedata <= writedata_d;
            read      <= read_d;
            readaddr  <= readaddr_d;
            sink_we   <= sink_we_d;
            sink_idx  <= sink_idx_d;
            sink_data <= sink_data_d;
            wr_done   <= wr_done_d;
            rd_done   <= rd_done_d;
            rd_err    <= rd_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmr_d       = tmr_q;
        wr_pend_d   = wr_pend_q;
        rd_pend_d   = rd_pend_q | rd_start;
        src_idx_d   = src_idx;
        write_d     = 1'b0;
        writeaddr_d = writeaddr;
        writedata_d = writedata;
        read_d      = 1'b0;
        readaddr_d  = readaddr;
        sink_we_d   = 1'b0;
        sink_idx_d  = sink_idx;
        sink_data_d = sink_data;
        wr_done_d   = 1'b0;
        rd_done_d   = 1'b0;
        rd_err_d    = rd_err;

        // A vs edge during a write burst is dropped; during a read burst it
        // is remembered and serviced once the read finishes.
        if (vs_rise && (state_q == R_REQ || state_q == R_WAIT)) begin
            wr_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Writes win; a simultaneous rd_start stays in rd_pend_d.
                if (wr_pend_q || vs_rise) begin
                    state_d   = W_FETCH;
                    cnt_d     = '0;
                    wr_pend_d = 1'b0;
                end else if (rd_pend_q || rd_start) begin
                    state_d   = R_REQ;
                    cnt_d     = '0;
                    rd_pend_d = 1'b0;
                end
            end
            W_FETCH: begin
                src_idx_d = cnt_q;
                state_d   = W_REQ;
            end
            W_REQ: begin
                if (!wr_full) begin
                    write_d     = 1'b1;
                    writeaddr_d = WR_START + cnt_q;
                    writedata_d = src_data;
                    state_d     = W_ACK;
                end
            end
            W_ACK: begin
                if (cnt_q == WR_LAST) begin
                    wr_done_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                    state_d = W_FETCH;
                end
            end
            R_REQ: begin
                read_d     = 1'b1;
                readaddr_d = RD_START + cnt_q;
                tmr_d      = '0;
                state_d    = R_WAIT;
            end
            R_WAIT: begin
                if (!rd_empty) begin
                    sink_we_d   = 1'b1;
                    sink_data_d = readdata;
                    sink_idx_d  = cnt_q;
                    if (cnt_q == RD_LAST) begin
                        rd_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = R_REQ;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    rd_err_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vram_xfer_seq.sv
// Scoreboard bench for vram_xfer_seq (WR_WORDS=4, WR_BASE=0x10, RD_WORDS=2,
// RD_BASE=3, TIMEOUT=8). Stimulus pushes expected writes, reads, sink words
// and done pulses; a negedge monitor pops and compares them.
module tb_vram_xfer_seq;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } pair_t;

    logic        clk;
    logic        reset_n;
    logic        vs;
    logic        rd_start;
    logic        wr_full;
    logic        rd_empty;
    logic [15:0] readdata;
    logic [15:0] src_data;
    logic [15:0] src_idx;
    logic        write;
    logic        read;
    logic [15:0] writeaddr;
    logic [15:0] readaddr;
    logic [15:0] writedata;
    logic        sink_we;
    logic [15:0] sink_idx;
    logic [15:0] sink_data;
    logic        busy;
    logic        wr_done;
    logic        rd_done;
    logic        rd_err;

    pair_t       exp_wr[$];
    pair_t       exp_sink[$];
    logic [15:0] exp_rd[$];
    int          exp_wr_done = 0;
    int          exp_rd_done = 0;

    int n_cmp = 0;
    int n_bad = 0;

    vram_xfer_seq #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .WR_WORDS (4),
        .RD_WORDS (2),
        .WR_BASE  ('h10),
        .RD_BASE  (3),
        .TIMEOUT  (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .vs        (vs),
        .rd_start  (rd_start),
        .wr_full   (wr_full),
        .rd_empty  (rd_empty),
        .readdata  (readdata),
        .src_data  (src_data),
        .src_idx   (src_idx),
        .write     (write),
        .read      (read),
        .writeaddr (writeaddr),
        .readaddr  (readaddr),
        .writedata (writedata),
        .sink_we   (sink_we),
        .sink_idx  (sink_idx),
        .sink_data (sink_data),
        .busy      (busy),
        .wr_done   (wr_done),
        .rd_done   (rd_done),
        .rd_err    (rd_err)
    );

    // Source memory: word i holds 0xA0 + i.
    assign src_data = src_idx + 16'h00A0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    pair_t mon_p;
    logic  prev_write = 1'b0;
    logic  prev_read  = 1'b0;
    logic  prev_sink  = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (write) begin
                check("write_width", {31'd0, prev_write}, 0);
                check("write_expected", {31'd0, exp_wr.size() != 0}, 1);
                if (exp_wr.size() != 0) begin
                    mon_p = exp_wr.pop_front();
                    check("writeaddr", {16'd0, writeaddr}, {16'd0, mon_p.a});
                    check("writedata", {16'd0, writedata}, {16'd0, mon_p.d});
                end
            end
            if (read) begin
                check("read_width", {31'd0, prev_read}, 0);
                check("read_after_writes", exp_wr.size(), 0);
                check("read_expected", {31'd0, exp_rd.size() != 0}, 1);
                if (exp_rd.size() != 0) begin
                    check("readaddr", {16'd0, readaddr}, {16'd0, exp_rd.pop_front()});
                end
            end
            if (sink_we) begin
                check("sink_width", {31'd0, prev_sink}, 0);
                check("sink_expected", {31'd0, exp_sink.size() != 0}, 1);
                if (exp_sink.size() != 0) begin
                    mon_p = exp_sink.pop_front();
                    check("sink_idx", {16'd0, sink_idx}, {16'd0, mon_p.a});
                    check("sink_data", {16'd0, sink_data}, {16'd0, mon_p.d});
                end
            end
            if (wr_done) begin
                check("wr_done_expected", {31'd0, exp_wr_done > 0}, 1);
                if (exp_wr_done > 0) exp_wr_done--;
            end
            if (rd_done) begin
                check("rd_done_expected", {31'd0, exp_rd_done > 0}, 1);
                if (exp_rd_done > 0) exp_rd_done--;
            end
            prev_write = write;
            prev_read  = read;
            prev_sink  = sink_we;
        end else begin
            prev_write = 1'b0;
            prev_read  = 1'b0;
            prev_sink  = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string name, input int budget, output int cycles);
        cycles = 0;
        while (busy && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check({name, "_idle"}, {31'd0, busy}, 0);
    endtask

    task automatic wait_read(input string name, input int budget);
        int c;
        c = 0;
        while (!read && c < budget) begin
            @(negedge clk);
            c++;
        end
        check({name, "_read_seen"}, {31'd0, read}, 1);
    endtask

    // VRAM answers one cycle after the read pulse.
    task automatic respond(input string name, input logic [15:0] d);
        wait_read(name, 60);
        @(negedge clk);
        rd_empty = 1'b0;
        readdata = d;
        @(negedge clk);
        rd_empty = 1'b1;
    endtask

    task automatic push_frame();
        for (int i = 0; i < 4; i++) begin
            exp_wr.push_back('{a: 16'h0010 + 16'(i), d: 16'h00A0 + 16'(i)});
        end
        exp_wr_done++;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_flags"}, {25'd0, busy, write, read, sink_we, wr_done, rd_done, rd_err}, 0);
        check({name, "_src_idx"}, {16'd0, src_idx}, 0);
        check({name, "_writeaddr"}, {16'd0, writeaddr}, 0);
        check({name, "_writedata"}, {16'd0, writedata}, 0);
        check({name, "_readaddr"}, {16'd0, readaddr}, 0);
        check({name, "_sink_idx"}, {16'd0, sink_idx}, 0);
        check({name, "_sink_data"}, {16'd0, sink_data}, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int busy_cnt;

        reset_n  = 1'b1;
        vs       = 1'b0;
        rd_start = 1'b0;
        wr_full  = 1'b0;
        rd_empty = 1'b1;
        readdata = '0;
        #3 reset_n = 1'b0;
        tick(2);
        check_all_zero("reset");
        reset_n = 1'b1;
        tick(2);

        // Plain write frame: 4 words, 3 cycles each.
        push_frame();
        vs = 1'b1;
        tick(1);
        check("wr1_busy", {31'd0, busy}, 1);
        wait_idle("wr1", 60, cyc);
        check("wr1_cycles", cyc, 12);
        // vs still high: no second burst.
        busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (busy) busy_cnt++;
        end
        check("vs_held_no_retrigger", busy_cnt, 0);
        vs = 1'b0;
        tick(2);

        // Back-pressure on word 1 for 5 cycles.
        push_frame();
        vs = 1'b1;
        cyc = 0;
        while (src_idx != 16'd1 && cyc < 40) begin
            tick(1);
            cyc++;
        end
        check("stall_reached_word1", {16'd0, src_idx}, 1);
        wr_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("stall_write_low", {31'd0, write}, 0);
        end
        wr_full = 1'b0;
        wait_idle("wr2", 60, cyc);
        vs = 1'b0;
        tick(2);

        // Read burst of 2 words from address 3.
        exp_rd.push_back(16'd3);
        exp_rd.push_back(16'd4);
        exp_sink.push_back('{a: 16'd0, d: 16'h0003});
        exp_sink.push_back('{a: 16'd1, d: 16'h0004});
        exp_rd_done++;
        rd_start = 1'b1;
        tick(1);
        rd_start = 1'b0;
        respond("rd1_w0", 16'h0003);
        respond("rd1_w1", 16'h0004);
        wait_idle("rd1", 20, cyc);
        tick(2);

        // vs edge and rd_start together: write first, read afterwards.
        push_frame();
        exp_rd.push_back(16'd3);
        exp_rd.push_back(16'd4);
        exp_sink.push_back('{a: 16'd0, d: 16'h0055});
        exp_sink.push_back('{a: 16'd1, d: 16'h0066});
        exp_rd_done++;
        vs       = 1'b1;
        rd_start = 1'b1;
        tick(1);
        rd_start = 1'b0;
        respond("both_w0", 16'h0055);
        respond("both_w1", 16'h0066);
        wait_idle("both", 20, cyc);
        vs = 1'b0;
        tick(2);

        // Read timeout: no data ever arrives.
        exp_rd.push_back(16'd3);
        check("rd_err_before", {31'd0, rd_err}, 0);
        rd_start = 1'b1;
        tick(1);
        rd_start = 1'b0;
        wait_read("tmo", 20);
        for (int i = 1; i < 8; i++) begin
            tick(1);
            check("tmo_err_low", {31'd0, rd_err}, 0);
            check("tmo_busy", {31'd0, busy}, 1);
        end
        tick(1);
        check("tmo_err_set", {31'd0, rd_err}, 1);
        check("tmo_idle", {31'd0, busy}, 0);
        tick(2);

        // Reset in the middle of a write burst, vs kept high across it.
        exp_wr.push_back('{a: 16'h0010, d: 16'h00A0});
        vs = 1'b1;
        tick(3);
        #1 reset_n = 1'b0;
        #1 check_all_zero("midrst");
        tick(2);
        reset_n = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (busy) busy_cnt++;
        end
        check("post_reset_vs_high", busy_cnt, 0);
        vs = 1'b0;
        tick(2);
        push_frame();
        vs = 1'b1;
        tick(1);
        wait_idle("wr3", 60, cyc);
        check("wr3_cycles", cyc, 12);
        vs = 1'b0;
        tick(3);

        check("left_writes", exp_wr.size(), 0);
        check("left_reads", exp_rd.size(), 0);
        check("left_sinks", exp_sink.size(), 0);
        check("left_wr_done", exp_wr_done, 0);
        check("left_rd_done", exp_rd_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
